// File: rtl/procyon_ccu_ifq_if.sv
// Fetch-queue bus bundle: icache alloc requests, CCU issue/complete, icache fill.
interface procyon_ccu_ifq_if #(
    parameter int unsigned OPTN_ADDR_WIDTH   = 32,
    parameter int unsigned OPTN_IC_LINE_SIZE = 32,
    parameter int unsigned OPTN_IFQ_DEPTH    = 4
);
    localparam int unsigned IC_LINE_WIDTH   = OPTN_IC_LINE_SIZE * 8;
    localparam int unsigned IC_OFFSET_WIDTH = $clog2(OPTN_IC_LINE_SIZE);
    localparam int unsigned IFQ_IDX_WIDTH   = $clog2(OPTN_IFQ_DEPTH);
    localparam int unsigned LA_WIDTH        = OPTN_ADDR_WIDTH - IC_OFFSET_WIDTH;

    logic                     i_alloc_en;
    logic [LA_WIDTH-1:0]      i_alloc_addr;
    logic                     o_ifq_full;
    logic                     o_alloc_merged;
    logic                     o_ccu_req_valid;
    logic [LA_WIDTH-1:0]      o_ccu_req_addr;
    logic [IFQ_IDX_WIDTH-1:0] o_ccu_req_idx;
    logic                     i_ccu_req_ack;
    logic                     i_ccu_done;
    logic [IFQ_IDX_WIDTH-1:0] i_ccu_done_idx;
    logic [IC_LINE_WIDTH-1:0] i_ccu_data;
    logic                     o_fill_en;
    logic [LA_WIDTH-1:0]      o_fill_addr;
    logic [IC_LINE_WIDTH-1:0] o_fill_data;

    // Environment side: drives requests, acks and completions.
    modport master (
        output i_alloc_en, i_alloc_addr, i_ccu_req_ack, i_ccu_done, i_ccu_done_idx, i_ccu_data,
        input  o_ifq_full, o_alloc_merged, o_ccu_req_valid, o_ccu_req_addr, o_ccu_req_idx,
               o_fill_en, o_fill_addr, o_fill_data
    );

    // Queue side.
    modport slave (
        input  i_alloc_en, i_alloc_addr, i_ccu_req_ack, i_ccu_done, i_ccu_done_idx, i_ccu_data,
        output o_ifq_full, o_alloc_merged, o_ccu_req_valid, o_ccu_req_addr, o_ccu_req_idx,
               o_fill_en, o_fill_addr, o_fill_data
    );
endinterface

// File: rtl/procyon_ccu_ifq.sv
// Multi-entry instruction fetch queue: merges duplicate line fetches, issues
// lines to the CCU in allocation order and returns filled lines to the icache.
module procyon_ccu_ifq #(
    parameter int unsigned OPTN_ADDR_WIDTH   = 32,
    parameter int unsigned OPTN_IC_LINE_SIZE = 32,
    parameter int unsigned OPTN_IFQ_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    procyon_ccu_ifq_if.slave bus
);
    localparam int unsigned IC_LINE_WIDTH   = OPTN_IC_LINE_SIZE * 8;
    localparam int unsigned IC_OFFSET_WIDTH = $clog2(OPTN_IC_LINE_SIZE);
    localparam int unsigned IFQ_IDX_WIDTH   = $clog2(OPTN_IFQ_DEPTH);
    localparam int unsigned LA_WIDTH        = OPTN_ADDR_WIDTH - IC_OFFSET_WIDTH;
    localparam int unsigned CNT_WIDTH       = IFQ_IDX_WIDTH + 1;

    typedef enum logic [1:0] {
        INVALID = 2'b00,
        VALID   = 2'b01,
        BUSY    = 2'b10
    } ifq_state_t;

    ifq_state_t               r_state      [OPTN_IFQ_DEPTH];
    ifq_state_t               w_state_next [OPTN_IFQ_DEPTH];
    logic [LA_WIDTH-1:0]      r_addr       [OPTN_IFQ_DEPTH];
    logic [IFQ_IDX_WIDTH-1:0] r_fifo       [OPTN_IFQ_DEPTH];
    logic [IFQ_IDX_WIDTH-1:0] r_rd_ptr;
    logic [IFQ_IDX_WIDTH-1:0] r_wr_ptr;
    logic [CNT_WIDTH-1:0]     r_count;
    logic                     r_fill_en;
    logic [LA_WIDTH-1:0]      r_fill_addr;
    logic [IC_LINE_WIDTH-1:0] r_fill_data;

    logic [OPTN_IFQ_DEPTH-1:0] w_occupied;
    logic [OPTN_IFQ_DEPTH-1:0] w_match_vec;
    logic                      w_match;
    logic                      w_full;
    logic                      w_alloc;
    logic [IFQ_IDX_WIDTH-1:0]  w_alloc_idx;
    logic                      w_fifo_empty;
    logic [IFQ_IDX_WIDTH-1:0]  w_head_idx;
    logic                      w_pop;
    logic                      w_done;

    // Occupancy and address match; BUSY entries completing now still match.
    always_comb begin
        w_occupied  = '0;
        w_match_vec = '0;
        for (int i = 0; i < int'(OPTN_IFQ_DEPTH); i++) begin
            w_occupied[i]  = (r_state[i] == VALID) || (r_state[i] == BUSY);
            w_match_vec[i] = w_occupied[i] && (r_addr[i] == bus.i_alloc_addr);
        end
    end

    // Lowest-index free entry from registered state only.
    always_comb begin
        w_alloc_idx = '0;
        for (int i = int'(OPTN_IFQ_DEPTH) - 1; i >= 0; i--) begin
            if (!w_occupied[i]) w_alloc_idx = IFQ_IDX_WIDTH'(i);
        end
    end

    assign w_match      = |w_match_vec;
    assign w_full       = &w_occupied;
    assign w_alloc      = bus.i_alloc_en && !w_match && !w_full;
    assign w_fifo_empty = (r_count == '0);
    assign w_head_idx   = r_fifo[r_rd_ptr];
    assign w_pop        = bus.i_ccu_req_ack && !w_fifo_empty;
    assign w_done       = bus.i_ccu_done && (r_state[bus.i_ccu_done_idx] == BUSY);

    // Per-entry state register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(OPTN_IFQ_DEPTH); i++) begin
            if (rst) r_state[i] <= INVALID;
            else     r_state[i] <= w_state_next[i];
        end
    end

    // Per-entry next state: alloc -> VALID, head ack -> BUSY, done -> INVALID.
    always_comb begin
        for (int i = 0; i < int'(OPTN_IFQ_DEPTH); i++) begin
            w_state_next[i] = r_state[i];
            case (r_state[i])
                INVALID: if (w_alloc && (w_alloc_idx == IFQ_IDX_WIDTH'(i))) w_state_next[i] = VALID;
                VALID:   if (w_pop && (w_head_idx == IFQ_IDX_WIDTH'(i)))    w_state_next[i] = BUSY;
                BUSY:    if (w_done && (bus.i_ccu_done_idx == IFQ_IDX_WIDTH'(i))) w_state_next[i] = INVALID;
                default: w_state_next[i] = INVALID;
            endcase
        end
    end

    // Line address capture on allocation.
    always_ff @(posedge clk) begin
        if (w_alloc) r_addr[w_alloc_idx] <= bus.i_alloc_addr;
    end

    // Issue FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_alloc) r_wr_ptr <= r_wr_ptr + IFQ_IDX_WIDTH'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + IFQ_IDX_WIDTH'(1);
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue FIFO storage of entry indices.
    always_ff @(posedge clk) begin
        if (w_alloc) r_fifo[r_wr_ptr] <= w_alloc_idx;
    end

    // Fill strobe, one cycle after an honoured completion.
    always_ff @(posedge clk) begin
        if (rst) r_fill_en <= 1'b0;
        else     r_fill_en <= w_done;
    end

    // Fill payload.
    always_ff @(posedge clk) begin
        if (w_done) begin
            r_fill_addr <= r_addr[bus.i_ccu_done_idx];
            r_fill_data <= bus.i_ccu_data;
        end
    end

    assign bus.o_ifq_full      = w_full;
    assign bus.o_alloc_merged  = bus.i_alloc_en && w_match;
    assign bus.o_ccu_req_valid = !w_fifo_empty;
    assign bus.o_ccu_req_idx   = w_head_idx;
    assign bus.o_ccu_req_addr  = r_addr[w_head_idx];
    assign bus.o_fill_en       = r_fill_en;
    assign bus.o_fill_addr     = r_fill_addr;
    assign bus.o_fill_data     = r_fill_data;

`ifndef SYNTHESIS
    // A completion must target an entry that is out at the CCU.
    a_done_busy: assert property (@(posedge clk) disable iff (rst)
        bus.i_ccu_done |-> (r_state[bus.i_ccu_done_idx] == BUSY));
`endif

endmodule

// File: tb/tb_procyon_ccu_ifq.sv
// Randomized + directed bench for procyon_ccu_ifq against a queue-based model.
module tb_procyon_ccu_ifq;
    localparam int unsigned AW  = 32;
    localparam int unsigned LS  = 32;
    localparam int unsigned D   = 4;
    localparam int unsigned LW  = LS * 8;
    localparam int unsigned OW  = $clog2(LS);
    localparam int unsigned IW  = $clog2(D);
    localparam int unsigned LAW = AW - OW;

    logic clk;
    logic rst;

    procyon_ccu_ifq_if #(.OPTN_ADDR_WIDTH(AW), .OPTN_IC_LINE_SIZE(LS), .OPTN_IFQ_DEPTH(D)) bus ();

    procyon_ccu_ifq #(.OPTN_ADDR_WIDTH(AW), .OPTN_IC_LINE_SIZE(LS), .OPTN_IFQ_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: outstanding lines, which are at the CCU, issue order.
    bit             m_known = 1'b0;
    bit             m_occ  [D];
    bit             m_busy [D];
    logic [LAW-1:0] m_addr [D];
    int             m_q    [$];
    bit             m_fill_en;
    logic [LAW-1:0] m_fill_addr;
    logic [LW-1:0]  m_fill_data;

    task automatic chk(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int i = 0; i < int'(LW / 32); i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cyc(input bit r, input bit en, input logic [LAW-1:0] a, input bit ack,
                       input bit dn, input int di, input logic [LW-1:0] dat);
        int  nocc;
        bit  match;
        int  free;
        @(negedge clk);
        rst                = r;
        bus.i_alloc_en     = en;
        bus.i_alloc_addr   = a;
        bus.i_ccu_req_ack  = ack;
        bus.i_ccu_done     = dn;
        bus.i_ccu_done_idx = IW'(di);
        bus.i_ccu_data     = dat;
        #1;
        nocc  = 0;
        match = 1'b0;
        for (int i = 0; i < int'(D); i++) begin
            if (m_occ[i]) begin
                nocc++;
                if (m_addr[i] == a) match = 1'b1;
            end
        end
        if (m_known) begin
            chk("full", LW'(bus.o_ifq_full), LW'(nocc == int'(D)));
            chk("merged", LW'(bus.o_alloc_merged), LW'(en && match));
            chk("req_valid", LW'(bus.o_ccu_req_valid), LW'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("req_idx", LW'(bus.o_ccu_req_idx), LW'(m_q[0]));
                chk("req_addr", LW'(bus.o_ccu_req_addr), LW'(m_addr[m_q[0]]));
            end
            chk("fill_en", LW'(bus.o_fill_en), LW'(m_fill_en));
            if (m_fill_en) begin
                chk("fill_addr", LW'(bus.o_fill_addr), LW'(m_fill_addr));
                chk("fill_data", bus.o_fill_data, m_fill_data);
            end
        end
        if (r) begin
            for (int i = 0; i < int'(D); i++) begin
                m_occ[i]  = 1'b0;
                m_busy[i] = 1'b0;
            end
            m_q.delete();
            m_fill_en = 1'b0;
            m_known   = 1'b1;
        end else begin
            free = -1;
            for (int i = int'(D) - 1; i >= 0; i--) if (!m_occ[i]) free = i;
            m_fill_en = dn && m_occ[di] && m_busy[di];
            if (m_fill_en) begin
                m_fill_addr = m_addr[di];
                m_fill_data = dat;
            end
            if (ack && m_q.size() != 0) begin
                m_busy[m_q[0]] = 1'b1;
                void'(m_q.pop_front());
            end
            if (m_fill_en) begin
                m_occ[di]  = 1'b0;
                m_busy[di] = 1'b0;
            end
            if (en && !match && free >= 0) begin
                m_occ[free]  = 1'b1;
                m_busy[free] = 1'b0;
                m_addr[free] = a;
                m_q.push_back(free);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 0, rnd_line());
    endtask

    task automatic alloc(input logic [LAW-1:0] a, input bit ack);
        cyc(1'b0, 1'b1, a, ack, 1'b0, 0, rnd_line());
    endtask

    task automatic done(input int di, input logic [LW-1:0] dat);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, di, dat);
    endtask

    initial begin
        logic [LW-1:0] a5;
        int            busy_list [$];
        bit            en, ack, dn, r;
        int            di;
        for (int i = 0; i < int'(LW / 8); i++) a5[i*8 +: 8] = 8'hA5;

        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 0, '0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 0, '0);

        // Basic alloc / ack / done / fill.
        alloc(LAW'('h100), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 0, rnd_line());
        idle(1);
        done(0, a5);
        idle(2);

        // Merge against a BUSY entry.
        alloc(LAW'('h100), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 0, rnd_line());
        alloc(LAW'('h100), 1'b0);
        done(0, rnd_line());
        idle(2);

        // Fill the queue, drop on full, reuse the freed entry.
        for (int i = 0; i < 4; i++) alloc(LAW'('h10 + i), 1'b0);
        alloc(LAW'('h20), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 0, rnd_line());
        done(2, rnd_line());
        alloc(LAW'('h20), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 0, rnd_line());
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 0, rnd_line());
        done(0, rnd_line());
        done(1, rnd_line());
        done(3, rnd_line());
        done(2, rnd_line());
        idle(2);

        // In-order issue, out-of-order completion.
        alloc(LAW'('h30), 1'b0);
        alloc(LAW'('h31), 1'b1);
        alloc(LAW'('h32), 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 0, rnd_line());
        done(2, rnd_line());
        done(0, rnd_line());
        done(1, rnd_line());
        idle(2);

        // Request for a line completing in the same cycle merges.
        alloc(LAW'('h40), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 0, rnd_line());
        cyc(1'b0, 1'b1, LAW'('h40), 1'b0, 1'b1, 0, rnd_line());
        idle(2);

        // Reset with outstanding work; a stale completion gives no fill.
        alloc(LAW'('h50), 1'b0);
        alloc(LAW'('h51), 1'b1);
        alloc(LAW'('h52), 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 0, rnd_line());
        idle(2);

        // Random traffic with a small address pool to force merges and fullness.
        for (int n = 0; n < 4000; n++) begin
            busy_list.delete();
            for (int i = 0; i < int'(D); i++) if (m_occ[i] && m_busy[i]) busy_list.push_back(i);
            r   = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 1) == 1);
            ack = ($urandom_range(0, 2) != 0);
            dn  = (busy_list.size() != 0) && ($urandom_range(0, 2) == 0);
            di  = dn ? busy_list[$urandom_range(0, busy_list.size() - 1)] : int'($urandom_range(0, D - 1));
            cyc(r, en, LAW'('h60 + $urandom_range(0, 7)), ack, dn, di, rnd_line());
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
